cdf_builder: RTL and testbench
==============================

# cdf_builder

Upstream stage of the histogram-equalization pipeline, feeding `divider.cdf_in`. Accepts one frame of `SIZE` 8-bit pixels and accumulates a 256-bin histogram. It then streams the cumulative distribution function, one bin per cycle from bin 0 to 255, and reports the frame's minimum non-zero CDF value for use as CDFMIN. Bins are cleared automatically after each frame, so frames run back-to-back.

## Interface
- `SIZE`, default 64: pixels per frame; range 1..255.
- `BINS`, default 256: histogram bins; fixed, equal to the 8-bit pixel range.
- `clk`  input  1  single clock; all state updates on the rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `pix_in`  input  8  pixel value, which is the bin index.
- `pix_valid`  input  1  `pix_in` is valid this cycle.
- `pix_ready`  output  1  high when the block accepts pixels; equal to (state == ACCUM).
- `cdf_out`  output  8  registered cumulative count through bin `cdf_idx`.
- `cdf_idx`  output  8  bin index of `cdf_out`.
- `cdf_valid`  output  1  `cdf_out`/`cdf_idx` valid.
- `cdf_min`  output  8  first non-zero CDF value of the last completed frame.
- `done`  output  1  one-cycle pulse after bin 255 is emitted.

## Operation
- Storage: 256 × 8-bit bin registers `hist[]`, an 8-bit pixel counter `pcnt`, an 8-bit scan index `sidx`, an 8-bit running sum `acc`, and a `min_found` flag.
- Reset:
  - all `hist[]`, `pcnt`, `sidx`, `acc` are 0; state is ACCUM.
  - `cdf_out` = 0, `cdf_idx` = 0, `cdf_valid` = 0, `cdf_min` = 0, `done` = 0.
  - `pix_ready` = 1 in the cycle after the reset edge.
- ACCUM:
  - on `pix_valid`: `hist[pix_in]` += 1 and `pcnt` += 1.
  - when the accepted pixel makes `pcnt` equal `SIZE`: state becomes SCAN; `pcnt`, `sidx`, `acc` and `min_found` are cleared.
  - counts cannot exceed `SIZE` ≤ 255, so no saturation is needed.
- SCAN, each cycle:
  - `acc_next` = `acc` + `hist[sidx]`.
  - register `cdf_out` = `acc_next`, `cdf_idx` = `sidx`, `cdf_valid` = 1.
  - if `min_found` = 0 and `acc_next` ≠ 0: `cdf_min` = `acc_next` and `min_found` = 1.
  - if `sidx` = 255: state becomes DONE; otherwise `sidx` += 1.
- DONE (one cycle):
  - `cdf_valid` = 0, `done` = 1, all `hist[]` = 0; state becomes ACCUM.
- `pix_valid` outside ACCUM is ignored, with no side effects.
- `cdf_min` holds from the SCAN in which it is set until the next frame's first non-zero bin. It is stable while `done` is high.
- The final `cdf_out` (bin 255) always equals `SIZE`.

## Timing
- Let E0 be the edge that accepts the last pixel of the frame.
- Edges E1..E256 register bins 0..255: `cdf_valid` is high for exactly 256 consecutive cycles with `cdf_idx` incrementing by 1.
- At E257: `cdf_valid` falls, `done` rises, and the bins clear. At E258: `done` falls.
- `pix_ready` is high again after E257; the next frame's first pixel can be accepted at E258.
- Frame turnaround is 258 cycles after the last pixel.
- Throughput in ACCUM: one pixel per cycle. Gaps in `pix_valid` only stretch the ACCUM phase.
- There is no downstream backpressure; the consumer must take one CDF value per cycle.
- Reset has priority in every state. Reset during SCAN or DONE discards the frame:
  - `cdf_valid` and `done` are 0 after the reset edge.
  - all bins are cleared.

## Test plan
- 64 pixels all = 5: `cdf_out` = 0 for bins 0–4 and 64 for bins 5–255; `cdf_min` = 64; `done` at E257.
- Pixels 0..63 in order: `cdf_out[i]` = i+1 for i < 64 and 64 for i ≥ 64; `cdf_min` = 1; `cdf_idx` runs 0..255 contiguously.
- Same 64-pixel ramp with random `pix_valid` gaps: identical CDF stream; SCAN starts exactly one edge after the 64th accepted pixel.
- `pix_valid` held high with value 200 throughout SCAN and DONE: histogram unaffected, and `hist[200]` is 0 at the start of the next frame.
- Two back-to-back frames (all 0, then all 255): frame 2 gives `cdf_out` = 0 for bins 0–254, 64 for bin 255, `cdf_min` = 64; no residue from frame 1.
- `reset` asserted at bin 100 of SCAN: outputs return to reset values on the next edge; a following all-7 frame gives `cdf_min` = 64, bin 6 = 0, bin 7 = 64.

Source files
------------

// File: rtl/cdf_builder.sv
// cdf_builder: accumulates a per-frame 8-bit pixel histogram, then streams its CDF one bin per cycle and reports CDFMIN.
module cdf_builder #(
  parameter int SIZE = 64,
  parameter int BINS = 256
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] pix_in,
  input  logic       pix_valid,
  output logic       pix_ready,
  output logic [7:0] cdf_out,
  output logic [7:0] cdf_idx,
  output logic       cdf_valid,
  output logic [7:0] cdf_min,
  output logic       done
);
  typedef enum logic [1:0] {ACCUM, SCAN, FIN} state_t;
  state_t state;
  logic [7:0] hist [BINS];
  logic [7:0] pcnt, sidx, acc, acc_next;
  logic min_found;
  assign pix_ready = (state == ACCUM);
  assign acc_next = acc + hist[sidx];
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ACCUM;
      for (int i = 0; i < BINS; i++) hist[i] <= '0;
      pcnt <= '0;
      sidx <= '0;
      acc <= '0;
      min_found <= 1'b0;
      cdf_out <= '0;
      cdf_idx <= '0;
      cdf_valid <= 1'b0;
      cdf_min <= '0;
      done <= 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          done <= 1'b0;
          if (pix_valid) begin
            hist[pix_in] <= hist[pix_in] + 8'd1;
            if (pcnt == 8'(SIZE - 1)) begin
              state <= SCAN;
              pcnt <= '0;
              sidx <= '0;
              acc <= '0;
              min_found <= 1'b0;
            end else begin
              pcnt <= pcnt + 8'd1;
            end
          end
        end
        SCAN: begin
          acc <= acc_next;
          cdf_out <= acc_next;
          cdf_idx <= sidx;
          cdf_valid <= 1'b1;
          if (!min_found && acc_next != 8'd0) begin
            cdf_min <= acc_next;
            min_found <= 1'b1;
          end
          if (sidx == 8'(BINS - 1)) state <= FIN;
          else sidx <= sidx + 8'd1;
        end
        default: begin
          // bins clear here so the next frame starts from an empty histogram
          cdf_valid <= 1'b0;
          done <= 1'b1;
          for (int i = 0; i < BINS; i++) hist[i] <= '0;
          state <= ACCUM;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_cdf_builder.sv
// tb_cdf_builder: directed frames through cdf_builder with hand-computed CDF streams and timing.
module tb_cdf_builder;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [7:0] pix_in = '0;
  logic pix_valid = 1'b0;
  logic pix_ready, cdf_valid, done;
  logic [7:0] cdf_out, cdf_idx, cdf_min;
  int pass_cnt = 0;
  int total = 0;
  logic [7:0] got_cdf [256];
  logic [7:0] got_idx [256];
  logic [7:0] exp_cdf [256];
  int lat, vcnt;
  logic done_a, valid_a, ready_a, done_b, rdy_scan;
  logic [7:0] min_a;

  cdf_builder #(.SIZE(64), .BINS(256)) dut (
    .clk(clk), .reset(reset), .pix_in(pix_in), .pix_valid(pix_valid),
    .pix_ready(pix_ready), .cdf_out(cdf_out), .cdf_idx(cdf_idx),
    .cdf_valid(cdf_valid), .cdf_min(cdf_min), .done(done)
  );

  always #5 clk = ~clk;

  // mode: 0 all 5, 1 ramp 0..63, 2 all 0, 3 all 255, 4 all 7
  task automatic send(input int mode, input bit gaps, input bit hold);
    for (int k = 0; k < 64; k++) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        repeat ($urandom_range(1, 3)) begin
          @(negedge clk);
          pix_valid = 1'b0;
          pix_in = 8'd99;
        end
      end
      @(negedge clk);
      pix_in = (mode == 0) ? 8'd5 : (mode == 1) ? 8'(k) : (mode == 2) ? 8'd0 : (mode == 3) ? 8'd255 : 8'd7;
      pix_valid = 1'b1;
    end
    @(negedge clk);
    pix_in = 8'd200;
    pix_valid = hold;
  endtask

  task automatic capture();
    lat = 0;
    while (!cdf_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    vcnt = 0;
    for (int i = 0; i < 256; i++) begin
      got_cdf[i] = cdf_out;
      got_idx[i] = cdf_idx;
      vcnt += int'(cdf_valid);
      if (i == 10) rdy_scan = pix_ready;
      @(negedge clk);
    end
    done_a = done;
    valid_a = cdf_valid;
    ready_a = pix_ready;
    min_a = cdf_min;
    pix_valid = 1'b0;
    @(negedge clk);
    done_b = done;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if ({cdf_out, cdf_idx, cdf_valid, cdf_min, done, pix_ready} !== {8'd0, 8'd0, 1'b0, 8'd0, 1'b0, 1'b1})
      $display("FAIL reset_state got out=%0d idx=%0d valid=%b min=%0d done=%b ready=%b want 0 0 0 0 0 1",
               cdf_out, cdf_idx, cdf_valid, cdf_min, done, pix_ready);
    else pass_cnt++;
    reset = 1'b0;
  endtask

  task automatic test_all_five();
    int bad = -1;
    send(0, 1'b0, 1'b0);
    capture();
    for (int i = 0; i < 256; i++) begin
      exp_cdf[i] = (i < 5) ? 8'd0 : 8'd64;
      if (bad < 0 && (got_cdf[i] !== exp_cdf[i] || got_idx[i] !== 8'(i))) bad = i;
    end
    total++;
    if (bad >= 0) $display("FAIL five_stream bin %0d got cdf=%0d idx=%0d want cdf=%0d idx=%0d",
                           bad, got_cdf[bad], got_idx[bad], exp_cdf[bad], bad);
    else pass_cnt++;
    total++;
    if (min_a !== 8'd64) $display("FAIL five_min got %0d want 64", min_a);
    else pass_cnt++;
    total++;
    if (lat !== 1 || vcnt !== 256 || done_a !== 1'b1 || valid_a !== 1'b0 || done_b !== 1'b0 || ready_a !== 1'b1 || rdy_scan !== 1'b0)
      $display("FAIL five_timing got lat=%0d vcnt=%0d done257=%b valid257=%b done258=%b ready257=%b ready_scan=%b want 1 256 1 0 0 1 0",
               lat, vcnt, done_a, valid_a, done_b, ready_a, rdy_scan);
    else pass_cnt++;
  endtask

  task automatic test_ramp(input bit gaps);
    int bad = -1;
    send(1, gaps, 1'b0);
    capture();
    for (int i = 0; i < 256; i++) begin
      exp_cdf[i] = (i < 64) ? 8'(i + 1) : 8'd64;
      if (bad < 0 && (got_cdf[i] !== exp_cdf[i] || got_idx[i] !== 8'(i))) bad = i;
    end
    total++;
    if (bad >= 0) $display("FAIL ramp_stream gaps=%0b bin %0d got cdf=%0d idx=%0d want cdf=%0d idx=%0d",
                           gaps, bad, got_cdf[bad], got_idx[bad], exp_cdf[bad], bad);
    else pass_cnt++;
    total++;
    if (min_a !== 8'd1) $display("FAIL ramp_min gaps=%0b got %0d want 1", gaps, min_a);
    else pass_cnt++;
    total++;
    if (lat !== 1 || vcnt !== 256 || done_a !== 1'b1 || done_b !== 1'b0)
      $display("FAIL ramp_timing gaps=%0b got lat=%0d vcnt=%0d done257=%b done258=%b want 1 256 1 0",
               gaps, lat, vcnt, done_a, done_b);
    else pass_cnt++;
  endtask

  task automatic test_ignore_pixels();
    int bad = -1;
    send(1, 1'b0, 1'b1);
    capture();
    for (int i = 0; i < 256; i++) begin
      exp_cdf[i] = (i < 64) ? 8'(i + 1) : 8'd64;
      if (bad < 0 && got_cdf[i] !== exp_cdf[i]) bad = i;
    end
    total++;
    if (bad >= 0) $display("FAIL hold200_stream bin %0d got %0d want %0d", bad, got_cdf[bad], exp_cdf[bad]);
    else pass_cnt++;
    send(0, 1'b0, 1'b0);
    capture();
    total++;
    if (got_cdf[199] !== 8'd64 || got_cdf[200] !== 8'd64 || got_cdf[255] !== 8'd64)
      $display("FAIL hold200_residue got bin199=%0d bin200=%0d bin255=%0d want 64 64 64",
               got_cdf[199], got_cdf[200], got_cdf[255]);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int bad = -1;
    send(2, 1'b0, 1'b0);
    capture();
    total++;
    if (got_cdf[0] !== 8'd64 || got_cdf[255] !== 8'd64 || min_a !== 8'd64)
      $display("FAIL b2b_first got bin0=%0d bin255=%0d min=%0d want 64 64 64", got_cdf[0], got_cdf[255], min_a);
    else pass_cnt++;
    send(3, 1'b0, 1'b0);
    capture();
    for (int i = 0; i < 256; i++) begin
      exp_cdf[i] = (i < 255) ? 8'd0 : 8'd64;
      if (bad < 0 && (got_cdf[i] !== exp_cdf[i] || got_idx[i] !== 8'(i))) bad = i;
    end
    total++;
    if (bad >= 0) $display("FAIL b2b_second bin %0d got cdf=%0d idx=%0d want cdf=%0d idx=%0d",
                           bad, got_cdf[bad], got_idx[bad], exp_cdf[bad], bad);
    else pass_cnt++;
    total++;
    if (min_a !== 8'd64 || done_a !== 1'b1) $display("FAIL b2b_min got min=%0d done=%b want 64 1", min_a, done_a);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_scan();
    int n = 0;
    send(2, 1'b0, 1'b0);
    while (!(cdf_valid && cdf_idx == 8'd100) && n < 300) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (n >= 300) $display("FAIL midscan_reach got timeout want bin 100");
    else pass_cnt++;
    reset = 1'b1;
    @(negedge clk);
    total++;
    if ({cdf_out, cdf_idx, cdf_valid, cdf_min, done, pix_ready} !== {8'd0, 8'd0, 1'b0, 8'd0, 1'b0, 1'b1})
      $display("FAIL midscan_reset got out=%0d idx=%0d valid=%b min=%0d done=%b ready=%b want 0 0 0 0 0 1",
               cdf_out, cdf_idx, cdf_valid, cdf_min, done, pix_ready);
    else pass_cnt++;
    reset = 1'b0;
    send(4, 1'b0, 1'b0);
    capture();
    total++;
    if (got_cdf[0] !== 8'd0 || got_cdf[6] !== 8'd0 || got_cdf[7] !== 8'd64 || got_cdf[255] !== 8'd64 || min_a !== 8'd64)
      $display("FAIL midscan_next got bin0=%0d bin6=%0d bin7=%0d bin255=%0d min=%0d want 0 0 64 64 64",
               got_cdf[0], got_cdf[6], got_cdf[7], got_cdf[255], min_a);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_all_five();
    test_ramp(1'b0);
    test_ramp(1'b1);
    test_ignore_pixels();
    test_back_to_back();
    test_reset_mid_scan();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
